maxnet_controller: RTL

MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

---
 rtl/maxnet_controller.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/maxnet_controller.sv
// MAXNET competition sequencer.
//
// Runs one winner-take-all competition per accepted `go`: loads the initial
// activations, then repeats START -> WAIT -> UPDATE -> SETTLE -> CHECK until the
// output checker reports a winner (DONE), the PLUs overflow (ERR, err_ovf) or
// the iteration limit is reached (ERR, err_tmo).
//
// Parameters
//   ITER_W    width of the iteration counter
//   MAX_ITER  iteration limit before timeout (1 .. 2^ITER_W-1)
//   WD_CYCLES watchdog limit on cycles spent in WAIT (watchdog build only)
//
// Ports
//   clk, rst         single rising-edge clock, synchronous active-high reset
//   go               start request, sampled only while idle
//   plu_done         all PLUs finished the current pass
//   overflow         any PLU overflowed
//   finish           registered winner-valid flag from the output checker
//   eps_reg_we, we_prim, we_a_reg, mux_sel, start, rst_plu   datapath controls
//   busy, done, err_ovf, err_tmo                             status
//   iter_count       completed iterations of the current run
//
// Build option
//   MAXNET_CTRL_WATCHDOG_EN  when defined, a stall of WD_CYCLES cycles in WAIT
//                            without plu_done/overflow ends the run with err_tmo.
//
// Every output is a flop: the controls are decoded from the next state and
// registered, so they line up with the state register and no input reaches an
// output combinationally.
module maxnet_controller #(
  parameter int unsigned ITER_W    = 8,
  parameter int unsigned MAX_ITER  = 100,
  parameter int unsigned WD_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              plu_done,
  input  logic              overflow,
  input  logic              finish,
  output logic              eps_reg_we,
  output logic              we_prim,
  output logic              we_a_reg,
  output logic              mux_sel,
  output logic              start,
  output logic              rst_plu,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic              err_tmo,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StRearm,
    StStart,
    StWait,
    StUpdate,
    StSettle,
    StCheck,
    StDone,
    StErr
  } state_e;

  typedef struct packed {
    logic eps_reg_we;
    logic we_prim;
    logic we_a_reg;
    logic mux_sel;
    logic start;
    logic rst_plu;
    logic busy;
    logic done;
  } ctrl_t;

  // Held PLU reset while rst is asserted; everything else quiet.
  localparam ctrl_t CtrlRst = '{rst_plu: 1'b1, default: 1'b0};

  localparam logic [ITER_W-1:0] MaxIterC = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] IterSat  = '1;

  state_e            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_tmo_q, err_tmo_d;
  logic              wd_expired;

  // ---------------------------------------------------------------------------
  // Optional WAIT watchdog
  // ---------------------------------------------------------------------------
`ifdef MAXNET_CTRL_WATCHDOG_EN
  localparam int unsigned    WdW    = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(WD_CYCLES - 1);

  logic [WdW-1:0] wd_q;

  // Counts cycles already spent in WAIT; zero on the first WAIT cycle because
  // WAIT is always entered from START.
  always_ff @(posedge clk) begin
    if (rst || (state_q != StWait)) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WdW'(1);
    end
  end

  // True in the WD_CYCLES-th WAIT cycle, so ERR follows exactly WD_CYCLES
  // cycles after WAIT was entered.
  assign wd_expired = (state_q == StWait) && (wd_q == WdLast);
`else
  logic [31:0] unused_wd_cycles;
  assign unused_wd_cycles = WD_CYCLES;
  assign wd_expired       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    err_ovf_d = err_ovf_q;
    err_tmo_d = err_tmo_q;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d   = StLoad;
          iter_d    = '0;
          err_ovf_d = 1'b0;
          err_tmo_d = 1'b0;
        end
      end
      StLoad:  state_d = StStart;
      StRearm: state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        // Overflow wins over a simultaneous plu_done: the results are garbage.
        if (overflow) begin
          state_d   = StErr;
          err_ovf_d = 1'b1;
        end else if (plu_done) begin
          state_d = StUpdate;
        end else if (wd_expired) begin
          state_d   = StErr;
          err_tmo_d = 1'b1;
        end
      end
      StUpdate: begin
        state_d = StSettle;
        if (iter_q != IterSat) begin
          iter_d = iter_q + ITER_W'(1);
        end
      end
      // One idle cycle so the registered finish flag sees the new activations.
      StSettle: state_d = StCheck;
      StCheck: begin
        if (finish) begin
          state_d = StDone;
        end else if (iter_q >= MaxIterC) begin
          state_d   = StErr;
          err_tmo_d = 1'b1;
        end else begin
          state_d = StRearm;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control decode of the state being entered; registered below so the
  // outputs coincide with the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d      = '0;
    ctrl_d.busy = (state_d != StIdle);

    unique case (state_d)
      StLoad: begin
        ctrl_d.eps_reg_we = 1'b1;
        ctrl_d.we_prim    = 1'b1;
        ctrl_d.we_a_reg   = 1'b1;
        ctrl_d.mux_sel    = 1'b1;
        ctrl_d.rst_plu    = 1'b1;
      end
      StRearm:  ctrl_d.rst_plu  = 1'b1;
      StStart:  ctrl_d.start    = 1'b1;
      // mux_sel stays 0 here: the activation register takes PLU results.
      StUpdate: ctrl_d.we_a_reg = 1'b1;
      StDone:   ctrl_d.done     = 1'b1;
      StErr:    ctrl_d.done     = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ctrl_q    <= CtrlRst;
      iter_q    <= '0;
      err_ovf_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      iter_q    <= iter_d;
      err_ovf_q <= err_ovf_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign eps_reg_we = ctrl_q.eps_reg_we;
  assign we_prim    = ctrl_q.we_prim;
  assign we_a_reg   = ctrl_q.we_a_reg;
  assign mux_sel    = ctrl_q.mux_sel;
  assign start      = ctrl_q.start;
  assign rst_plu    = ctrl_q.rst_plu;
  assign busy       = ctrl_q.busy;
  assign done       = ctrl_q.done;
  assign err_ovf    = err_ovf_q;
  assign err_tmo    = err_tmo_q;
  assign iter_count = iter_q;

endmodule
